cache_nway_wt: RTL and testbench

- Parametrised N-way set-associative cache, one word per line, write-through, no-write-allocate.
- Successor to the direct-mapped instruction/data cache used in the single-cycle core. Adds configurable ways, index and offset widths, a lookup/refill state machine, miss handling over a request/acknowledge memory port, and a flush command.
- Sits between the core's load/store port and backing memory.

---
 rtl/cache_nway_wt.sv | 246 ++++++++++++++++++++++++
 tb/tb_cache_nway_wt.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wt.sv
// N-way set-associative write-through cache, one word per line, no-write-allocate.
// Misses and all writes go to backing memory over a req/ack port; round-robin victim per set.
module cache_nway_wt #(
   parameter int ADDRW = 32,
   parameter int DATAW = 32,
   parameter int IDXW  = 10,
   parameter int OFFW  = 2,
   parameter int WAYS  = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [ADDRW-1:0] addr_i,
   input  logic [DATAW-1:0] wdata_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             resp_o,
   output logic             hit_o,
   output logic [DATAW-1:0] rdata_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [ADDRW-1:0] mem_addr_o,
   output logic [DATAW-1:0] mem_wdata_o,
   input  logic             mem_ack_i,
   input  logic [DATAW-1:0] mem_rdata_i
);

   localparam int TAGW  = ADDRW - IDXW - OFFW;
   localparam int SETS  = 2 ** IDXW;
   localparam int LINEW = TAGW + IDXW;
   localparam int PTRW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   // RDSET is the cycle in which the registered index reads the set arrays.
   typedef enum logic [2:0] {IDLE, RDSET, LOOKUP, REFILL, WRITE} state_e;

   state_e                       state_q, state_d;
   logic [LINEW-1:0]             line_q, line_d;
   logic                         we_q, we_d;
   logic [DATAW-1:0]             wdata_q, wdata_d;
   logic                         whit_q, whit_d;
   logic                         busy_q, busy_d;
   logic                         resp_q, resp_d;
   logic                         hit_q, hit_d;
   logic [DATAW-1:0]             rdata_q, rdata_d;
   logic                         mem_req_q, mem_req_d;
   logic                         mem_we_q, mem_we_d;
   logic [ADDRW-1:0]             mem_addr_q, mem_addr_d;
   logic [DATAW-1:0]             mem_wdata_q, mem_wdata_d;
   logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
   logic [SETS-1:0][PTRW-1:0]    ptr_q, ptr_d;

   logic [TAGW-1:0]              tag_mem  [WAYS][SETS];
   logic [DATAW-1:0]             data_mem [WAYS][SETS];
   logic [TAGW-1:0]              rd_tag_q  [WAYS];
   logic [TAGW-1:0]              rd_tag_d  [WAYS];
   logic [DATAW-1:0]             rd_data_q [WAYS];
   logic [DATAW-1:0]             rd_data_d [WAYS];

   logic [TAGW-1:0]              tag_q;
   logic [IDXW-1:0]              idx_q;
   logic                         lk_hit;
   logic [PTRW-1:0]              hit_way;
   logic [DATAW-1:0]             lk_data;
   logic                         all_valid;
   logic [PTRW-1:0]              victim;
   logic [PTRW-1:0]              ptr_next;
   logic                         data_we;
   logic                         tag_we;
   logic [PTRW-1:0]              arr_way;
   logic [DATAW-1:0]             arr_data;
   logic                         unused_off;

   assign tag_q      = line_q[LINEW-1:IDXW];
   assign idx_q      = line_q[IDXW-1:0];
   assign unused_off = ^addr_i[OFFW-1:0];

   assign busy_o      = busy_q;
   assign resp_o      = resp_q;
   assign hit_o       = hit_q;
   assign rdata_o     = rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         rd_tag_d[w]  = tag_mem[w][idx_q];
         rd_data_d[w] = data_mem[w][idx_q];
      end
   end

   always_ff @(posedge clk_i) begin
      rd_tag_q  <= rd_tag_d;
      rd_data_q <= rd_data_d;
      for (int w = 0; w < WAYS; w++) begin
         if (data_we && arr_way == PTRW'(w)) data_mem[w][idx_q] <= arr_data;
         if (tag_we && arr_way == PTRW'(w))  tag_mem[w][idx_q]  <= tag_q;
      end
   end

   always_comb begin
      lk_hit  = 1'b0;
      hit_way = '0;
      lk_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx_q][w] && rd_tag_q[w] == tag_q) begin
            lk_hit  = 1'b1;
            hit_way = PTRW'(w);
            lk_data = rd_data_q[w];
         end
      end
   end

   // Lowest-index invalid way wins; only a full set falls back to the round-robin pointer.
   always_comb begin
      all_valid = &valid_q[idx_q];
      victim    = ptr_q[idx_q];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx_q][w]) victim = PTRW'(w);
      end
      ptr_next = (ptr_q[idx_q] == PTRW'(WAYS - 1)) ? '0 : ptr_q[idx_q] + PTRW'(1);
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      whit_d      = whit_q;
      resp_d      = 1'b0;
      hit_d       = hit_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = valid_q;
      ptr_d       = ptr_q;
      data_we     = 1'b0;
      tag_we      = 1'b0;
      arr_way     = hit_way;
      arr_data    = wdata_q;
      case (state_q)
         IDLE: begin
            if (flush_i) begin
               valid_d = '0;
               ptr_d   = '0;
            end else if (req_i) begin
               line_d  = addr_i[ADDRW-1:OFFW];
               we_d    = we_i;
               wdata_d = wdata_i;
               state_d = RDSET;
            end
         end
         RDSET: state_d = LOOKUP;
         LOOKUP: begin
            if (we_q) begin
               data_we     = lk_hit;
               whit_d      = lk_hit;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {line_q, {OFFW{1'b0}}};
               mem_wdata_d = wdata_q;
               state_d     = WRITE;
            end else if (lk_hit) begin
               rdata_d = lk_data;
               hit_d   = 1'b1;
               resp_d  = 1'b1;
               state_d = IDLE;
            end else begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {line_q, {OFFW{1'b0}}};
               state_d    = REFILL;
            end
         end
         REFILL: begin
            if (mem_ack_i) begin
               data_we  = 1'b1;
               tag_we   = 1'b1;
               arr_way  = victim;
               arr_data = mem_rdata_i;
               for (int w = 0; w < WAYS; w++) begin
                  if (victim == PTRW'(w)) valid_d[idx_q][w] = 1'b1;
               end
               if (all_valid) ptr_d[idx_q] = ptr_next;
               rdata_d   = mem_rdata_i;
               hit_d     = 1'b0;
               resp_d    = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         WRITE: begin
            if (mem_ack_i) begin
               hit_d     = whit_q;
               resp_d    = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         line_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         whit_q      <= 1'b0;
         busy_q      <= 1'b0;
         resp_q      <= 1'b0;
         hit_q       <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         valid_q     <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         whit_q      <= whit_d;
         busy_q      <= busy_d;
         resp_q      <= resp_d;
         hit_q       <= hit_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         ptr_q       <= ptr_d;
      end
   end

endmodule

// File: tb/tb_cache_nway_wt.sv
// Directed bench for cache_nway_wt (4-bit index, 2 ways): a reference memory supplies
// expected data, and response/memory-transaction expectations are queued and checked as they occur.
module tb_cache_nway_wt;

   localparam int ADDRW = 32;
   localparam int DATAW = 32;
   localparam int IDXW  = 4;
   localparam int OFFW  = 2;
   localparam int WAYS  = 2;

   logic             clk_i;
   logic             rst_ni;
   logic             req_i;
   logic             we_i;
   logic [ADDRW-1:0] addr_i;
   logic [DATAW-1:0] wdata_i;
   logic             flush_i;
   logic             busy_o;
   logic             resp_o;
   logic             hit_o;
   logic [DATAW-1:0] rdata_o;
   logic             mem_req_o;
   logic             mem_we_o;
   logic [ADDRW-1:0] mem_addr_o;
   logic [DATAW-1:0] mem_wdata_o;
   logic             mem_ack_i;
   logic [DATAW-1:0] mem_rdata_i;

   cache_nway_wt #(
      .ADDRW(ADDRW), .DATAW(DATAW), .IDXW(IDXW), .OFFW(OFFW), .WAYS(WAYS)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .flush_i(flush_i), .busy_o(busy_o), .resp_o(resp_o), .hit_o(hit_o),
      .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic        hit;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_t;

   int          checks = 0;
   int          errors = 0;
   resp_t       resp_q[$];
   mem_t        mexp_q[$];
   logic [31:0] bmem [logic [31:0]];
   bit          auto_ack = 1'b1;
   bit          noise = 1'b0;

   function automatic logic [31:0] memVal(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one request at the current negedge and queue what the cache and memory should do.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_hit);
      resp_t       r;
      mem_t        m;
      logic [31:0] line;
      line    = {addr[31:2], 2'b00};
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = addr;
      wdata_i = wdata;
      r.we    = we;
      r.hit   = exp_hit;
      r.rdata = we ? 32'h0 : memVal(line);
      if (we || !exp_hit) begin
         m.we    = we;
         m.addr  = line;
         m.wdata = wdata;
         mexp_q.push_back(m);
      end
      if (we) bmem[line] = wdata;
      resp_q.push_back(r);
      @(negedge clk_i);
      req_i = 1'b0;
      we_i  = 1'b0;
   endtask

   // Serve memory (ack 3 cycles after request) until resp_o, then score it; returns on that negedge.
   task automatic runUntilResp(input int budget);
      int    cyc = 0;
      int    wait_n = 0;
      bit    got = 1'b0;
      bit    in_txn = 1'b0;
      bit    acked_last;
      mem_t  m;
      resp_t r;
      while (!got && cyc < budget) begin
         @(negedge clk_i);
         cyc++;
         acked_last = mem_ack_i;
         mem_ack_i  = 1'b0;
         if (resp_o) begin
            got   = 1'b1;
            req_i = 1'b0;
            checkOutput("resp_expected", resp_q.size() != 0, 1);
            if (resp_q.size() != 0) begin
               r = resp_q.pop_front();
               checkOutput("hit_o", hit_o, r.hit);
               if (!r.we) checkOutput("rdata_o", rdata_o, r.rdata);
               if (!r.we && r.hit) checkOutput("hit_latency", cyc, 2);
               else checkOutput("ack_to_resp", acked_last, 1);
            end
         end else begin
            if (noise && busy_o) begin
               req_i  = ~req_i;
               addr_i = 32'h840;
               if (!mem_req_o && !in_txn) mem_ack_i = 1'b1;
            end
            if (auto_ack && mem_req_o) begin
               if (!in_txn) begin
                  in_txn = 1'b1;
                  wait_n = 0;
                  checkOutput("mem_txn_expected", mexp_q.size() != 0, 1);
                  if (mexp_q.size() != 0) m = mexp_q.pop_front();
                  checkOutput("mem_addr_o", mem_addr_o, m.addr);
                  checkOutput("mem_we_o", mem_we_o, m.we);
                  if (m.we) checkOutput("mem_wdata_o", mem_wdata_o, m.wdata);
               end
               wait_n++;
               if (wait_n == 3) begin
                  mem_ack_i   = 1'b1;
                  mem_rdata_i = m.we ? 32'h0 : memVal(m.addr);
                  in_txn      = 1'b0;
               end
            end
         end
      end
      checkOutput("resp_timeout", got, 1);
   endtask

   task automatic idleCheck(input int n);
      repeat (n) begin
         @(negedge clk_i);
         checkOutput("idle_quiet", {resp_o, mem_req_o, busy_o}, 3'b000);
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      req_i       = 1'b0;
      we_i        = 1'b0;
      addr_i      = '0;
      wdata_i     = '0;
      flush_i     = 1'b0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      bmem[32'h040] = 32'hDEADBEEF;

      repeat (3) @(negedge clk_i);
      checkOutput("reset_outs_init",
                  {busy_o, resp_o, hit_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("[TB] cold miss then hit");
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b0); runUntilResp(40);
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b1); runUntilResp(40);

      $display("[TB] conflict and round-robin eviction on set 0");
      applyStimulus(1'b0, 32'h440, 32'h0, 1'b0); runUntilResp(40);
      applyStimulus(1'b0, 32'h840, 32'h0, 1'b0); runUntilResp(40);
      applyStimulus(1'b0, 32'h440, 32'h0, 1'b1); runUntilResp(40);
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b0); runUntilResp(40);

      $display("[TB] write hit, write miss without allocate");
      applyStimulus(1'b1, 32'h040, 32'h12345678, 1'b1); runUntilResp(40);
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b1); runUntilResp(40);
      applyStimulus(1'b1, 32'h0C0, 32'hCAFEF00D, 1'b0); runUntilResp(40);
      applyStimulus(1'b0, 32'h0C0, 32'h0, 1'b0); runUntilResp(40);

      $display("[TB] flush");
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b1); runUntilResp(40);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      checkOutput("flush_not_busy", {busy_o, resp_o}, 2'b00);
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b0); runUntilResp(40);
      flush_i = 1'b1;
      req_i   = 1'b1;
      addr_i  = 32'h440;
      @(negedge clk_i);
      flush_i = 1'b0;
      req_i   = 1'b0;
      idleCheck(3);
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b0); runUntilResp(40);
      applyStimulus(1'b0, 32'h440, 32'h0, 1'b0); runUntilResp(40);

      $display("[TB] reset during refill");
      auto_ack = 1'b0;
      req_i    = 1'b1;
      we_i     = 1'b0;
      addr_i   = 32'h840;
      @(negedge clk_i);
      req_i = 1'b0;
      begin
         int k = 0;
         while (!mem_req_o && k < 10) begin
            @(negedge clk_i);
            k++;
         end
      end
      checkOutput("refill_req_seen", mem_req_o, 1);
      checkOutput("refill_addr", mem_addr_o, 32'h840);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checkOutput("reset_outs_refill",
                  {busy_o, resp_o, hit_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
      @(negedge clk_i);
      rst_ni      = 1'b1;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0BAD0BAD;
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      idleCheck(4);
      auto_ack = 1'b1;
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b0); runUntilResp(40);

      $display("[TB] req/ack noise while busy");
      noise = 1'b1;
      applyStimulus(1'b0, 32'h440, 32'h0, 1'b0); runUntilResp(40);
      noise  = 1'b0;
      req_i  = 1'b0;
      idleCheck(4);

      $display("[TB] back-to-back requests on resp cycles");
      applyStimulus(1'b0, 32'h440, 32'h0, 1'b1); runUntilResp(40);
      applyStimulus(1'b0, 32'h040, 32'h0, 1'b1); runUntilResp(40);
      applyStimulus(1'b1, 32'h840, 32'h55AA55AA, 1'b0); runUntilResp(40);
      applyStimulus(1'b0, 32'h840, 32'h0, 1'b0); runUntilResp(40);
      idleCheck(3);

      checkOutput("resp_q_drained", resp_q.size(), 0);
      checkOutput("mem_q_drained", mexp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
